// File: rtl/data_sram_responder.sv
// Slave end of the data SRAM request/addr_ok/data_ok interface: in-order pending queue,
// per-entry minimum latency, word-addressed backing memory. Optional: DATA_SRAM_RAND_STALL_EN.
module data_sram_responder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // The countdown is nominally LATENCY-1 at accept; the accept edge itself counts as one
    // step, so the stored value is one lower and the head pops in cycle T+LATENCY-1.
    localparam logic [CD_W-1:0] CD_INIT = (LATENCY > 1) ? CD_W'(LATENCY - 2) : '0;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [3:0]        wstrb;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       wdata;
        logic [CD_W-1:0]   cd;
    } entry_t;

    entry_t            entry_q [FIFO_DEPTH];
    entry_t            entry_d [FIFO_DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              data_ok_q, data_ok_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              accept;
    logic              pop;
    logic              stall_accept;
    logic              stall_retire;

    logic [31:0] mem [2**ADDR_W];

`ifdef DATA_SRAM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall_accept = lfsr_q[0];
        stall_retire = lfsr_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    always_comb begin
        stall_accept = 1'b0;
        stall_retire = 1'b0;
    end
`endif

    // Byte-offset and upper (aliased) address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Full queue blocks acceptance even when the head pops in the same cycle.
    assign data_sram_addr_ok = data_sram_req & (count_q < CNT_W'(FIFO_DEPTH)) & ~reset & ~stall_accept;
    assign accept            = data_sram_req & data_sram_addr_ok;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        entry_d = entry_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_d[i].cd != '0) entry_d[i].cd = entry_d[i].cd - CD_W'(1);
        end

        head = entry_q[rd_ptr_q];
        pop  = (count_q != '0) && (head.cd == '0) && !stall_retire;

        if (accept) begin
            entry_d[wr_ptr_q] = '{
                wr:    data_sram_wr,
                size:  data_sram_size,
                wstrb: data_sram_wstrb,
                idx:   data_sram_addr[ADDR_W+1:2],
                wdata: data_sram_wdata,
                cd:    CD_INIT
            };
        end

        wr_ptr_d  = wr_ptr_q + PTR_W'(accept);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
        data_ok_d = pop;
        rdata_d   = (pop && !head.wr) ? mem[head.idx] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    // NOTE: queue payload and memory carry no reset; validity lives in count/pointers,
    // and memory contents must survive reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    always_ff @(posedge clk) begin
        if (!reset && pop && head.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (head.wstrb[b]) mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
            end
        end
    end

    assign data_sram_data_ok = data_ok_q;
    assign data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: default instance (LATENCY=2) plus a LATENCY=8 instance.
module tb_data_sram_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        req8, wr8;
    logic [1:0]  size8;
    logic [3:0]  wstrb8;
    logic [31:0] addr8, wdata8;
    logic        addr_ok8, data_ok8;
    logic [31:0] rdata8;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit exact_lat = 1'b0;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
        int                acc_cyc;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [31:0] model_mem [2**ADDR_W];
    logic [31:0] last_rdata = '0;

    data_sram_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .LATENCY(LATENCY)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata)
    );

    data_sram_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .LATENCY(8)) u_dut8 (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req8),
        .data_sram_wr      (wr8),
        .data_sram_size    (size8),
        .data_sram_wstrb   (wstrb8),
        .data_sram_addr    (addr8),
        .data_sram_wdata   (wdata8),
        .data_sram_addr_ok (addr_ok8),
        .data_sram_data_ok (data_ok8),
        .data_sram_rdata   (rdata8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: memory commits at write retire, reads compare against committed state.
    always @(negedge clk) begin
        if (data_ok) begin
            if (sb.size() == 0) begin
                check("spurious_data_ok", 32'(data_ok), 32'd0);
            end else begin
                sb_entry_t e;
                int lat;
                e   = sb.pop_front();
                lat = cyc - e.acc_cyc;
                if (exact_lat) check("latency", 32'(lat), 32'(LATENCY));
                else           check("latency_min", 32'(lat >= LATENCY), 32'd1);
                if (e.wr) begin
                    for (int b = 0; b < 4; b++)
                        if (e.wstrb[b]) model_mem[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
                    check("rdata_hold_on_write", rdata, last_rdata);
                end else begin
                    check("rdata", rdata, model_mem[e.idx]);
                    last_rdata = model_mem[e.idx];
                end
            end
        end
        if (reset) begin
            sb.delete();
            last_rdata = '0;
        end else if (req && addr_ok) begin
            sb.push_back('{wr: wr, idx: addr[ADDR_W+1:2], wdata: wdata, wstrb: wstrb, acc_cyc: cyc});
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic acc;
        acc   = 1'b0;
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
        size  = 2'($urandom_range(0, 2));
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = addr_ok;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        if (!acc) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acc8, got8;
        logic [31:0] r;

        reset = 1'b1; req = 1'b1; wr = 1'b0; size = '0; wstrb = '0; addr = '0; wdata = '0;
        req8 = 1'b0; wr8 = 1'b0; size8 = '0; wstrb8 = '0; addr8 = '0; wdata8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("addr_ok_in_reset", 32'(addr_ok), 32'd0);
        check("data_ok_reset", 32'(data_ok), 32'd0);
        check("rdata_reset", rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_data_ok", 32'(data_ok), 32'd0);
        end
        @(posedge clk);
        #1;

        // Write then read back-to-back, exact latency.
        exact_lat = 1'b1;
        issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        wait_drain();
        @(negedge clk);
        check("raw_full_word", rdata, 32'hDEAD_BEEF);

        // Partial strobe write merges into the word.
        @(posedge clk);
        #1;
        issue(1'b1, 32'h0000_1001, 32'h0000_AB00, 4'b0010);
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        wait_drain();
        repeat (3) begin
            @(negedge clk);
            check("rdata_hold_idle", rdata, 32'hDEAD_ABEF);
        end

        // Upper address bits alias onto the same word.
        @(posedge clk);
        #1;
        issue(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF);
        issue(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        wait_drain();
        @(negedge clk);
        check("alias_read", rdata, 32'h1234_5678);
        exact_lat = 1'b0;

        // Reset drops an in-flight write.
        @(posedge clk);
        #1;
        issue(1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF);
        wait_drain();
        issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_drop_data_ok", 32'(data_ok), 32'd0);
        check("reset_rdata_zero", rdata, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("reset_no_late_ok", 32'(data_ok), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        wait_drain();
        @(negedge clk);
        check("reset_write_dropped", rdata, 32'h1111_2222);

        // LATENCY=8 instance: preload five words, then a held burst of five reads.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            req8 = 1'b1; wr8 = 1'b1; addr8 = 32'(i * 4); wdata8 = 32'h100 + 32'(i); wstrb8 = 4'hF;
            @(posedge clk);
            #1;
            req8 = 1'b0;
            repeat (12) @(posedge clk);
        end
        @(posedge clk);
        #1;
        req8 = 1'b1; wr8 = 1'b0; addr8 = '0;
        acc8 = 0;
        got8 = 0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            check($sformatf("lat8_addr_ok_c%0d", k), 32'(addr_ok8), 32'((k <= 3) || (k == 8)));
            check($sformatf("lat8_data_ok_c%0d", k), 32'(data_ok8),
                  32'((k == 8) || (k == 9) || (k == 10) || (k == 11) || (k == 16)));
            if (data_ok8) begin
                check("lat8_rdata_order", rdata8, 32'h100 + 32'(got8));
                got8++;
            end
            if (req8 && addr_ok8) acc8++;
            @(posedge clk);
            #1;
            if (acc8 >= 5) req8 = 1'b0;
            else           addr8 = 32'(acc8 * 4);
        end
        check("lat8_pulse_count", 32'(got8), 32'd5);

        // Random read/write mix over preloaded words, with aliasing and partial strobes.
        for (int j = 16; j < 24; j++) issue(1'b1, 32'(j * 4), $urandom(), 4'hF);
        for (int n = 0; n < 100; n++) begin
            int j;
            j = $urandom_range(16, 23);
            r = $urandom();
            issue(1'($urandom_range(0, 1)), {r[31:12], 10'(j), r[1:0]}, $urandom(), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
